// File: rtl/ones_pattern_gen.sv
// Serial ones-pattern generator: emits a 7-bit thermometer frame (bit 0 first)
// holding `count` ones, with an optional idle gap between frames.
module ones_pattern_gen #(
    parameter int GAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] count,
    output logic       sdata,
    output logic       sframe,
    output logic       slast,
    output logic [6:0] word,
    output logic       word_valid
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t     state_q;
    logic [2:0] idx_q;
    logic [2:0] cnt_q;
    logic [3:0] gap_q;
    logic       sdata_q, sframe_q, slast_q, word_valid_q;
    logic [6:0] word_q;
    logic [6:0] word_d;
    logic       accept;

    // With no gap, the last frame bit can overlap the next accept.
    assign in_ready = (state_q == S_IDLE) ||
                      ((state_q == S_SEND) && (idx_q == 3'd6) && (GAP == 0));
    assign accept   = in_valid && in_ready;
    assign word_d   = ~(7'h7F << count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= 3'd0;
            gap_q        <= 4'd0;
            sdata_q      <= 1'b0;
            sframe_q     <= 1'b0;
            slast_q      <= 1'b0;
            word_q       <= 7'd0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (accept) begin
                state_q      <= S_SEND;
                cnt_q        <= count;
                idx_q        <= 3'd0;
                word_q       <= word_d;
                word_valid_q <= 1'b1;
                sdata_q      <= (count != 3'd0);
                sframe_q     <= 1'b1;
                slast_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_SEND: begin
                        if (idx_q == 3'd6) begin
                            idx_q    <= 3'd0;
                            sdata_q  <= 1'b0;
                            sframe_q <= 1'b0;
                            slast_q  <= 1'b0;
                            if (GAP > 0) begin
                                state_q <= S_GAP;
                                gap_q   <= 4'd0;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            // Outputs are registered, so they reflect the next index.
                            idx_q   <= idx_q + 3'd1;
                            sdata_q <= ((idx_q + 3'd1) < cnt_q);
                            slast_q <= (idx_q == 3'd5);
                        end
                    end
                    S_GAP: begin
                        if (gap_q == GAP_LAST) begin
                            state_q <= S_IDLE;
                            gap_q   <= 4'd0;
                        end else begin
                            gap_q <= gap_q + 4'd1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sdata      = sdata_q;
    assign sframe     = sframe_q;
    assign slast      = slast_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen: one instance with GAP=0, one with GAP=2.
module tb_ones_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v0, v2;
    logic [2:0] c0, c2;
    logic       r0, r2, sd0, sd2, sf0, sf2, sl0, sl2, wv0, wv2;
    logic [6:0] w0, w2;

    int checks = 0;
    int errors = 0;
    logic [6:0] therm [8];

    ones_pattern_gen #(.GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .count(c0),
        .sdata(sd0), .sframe(sf0), .slast(sl0), .word(w0), .word_valid(wv0)
    );

    ones_pattern_gen #(.GAP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .count(c2),
        .sdata(sd2), .sframe(sf2), .slast(sl2), .word(w2), .word_valid(wv2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with dut0 idle; returns the serial bits seen.
    task automatic frame0(input logic [2:0] c, input logic [6:0] ew, output logic [6:0] bits);
        chk("frm_rdy", r0, 1'b1);
        v0 = 1'b1;
        c0 = c;
        @(negedge clk);
        v0 = 1'b0;
        c0 = 3'd0;
        for (int i = 0; i < 7; i++) begin
            chk("frm_sdata", sd0, ew[i]);
            chk("frm_sframe", sf0, 1'b1);
            chk("frm_slast", sl0, (i == 6));
            chk("frm_wvalid", wv0, (i == 0));
            chk("frm_word", w0, ew);
            bits[i] = sd0;
            @(negedge clk);
        end
        chk("frm_end_sframe", sf0, 1'b0);
        chk("frm_end_rdy", r0, 1'b1);
    endtask

    initial begin
        logic [6:0] bits;
        logic [2:0] bc [3];
        logic [6:0] bw [3];
        int run, ones, last_acc;

        therm = '{7'h00, 7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F};
        bc = '{3'd2, 3'd5, 3'd1};
        bw = '{7'b0000011, 7'b0011111, 7'b0000001};

        rst_n = 1'b0;
        v0 = 1'b0; v2 = 1'b0; c0 = 3'd0; c2 = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_sdata", sd0, 1'b0);
        chk("rst_sframe", sf0, 1'b0);
        chk("rst_slast", sl0, 1'b0);
        chk("rst_word", w0, 7'd0);
        chk("rst_wvalid", wv0, 1'b0);
        chk("rst_rdy", r0, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_sframe", sf0, 1'b0);

        frame0(3'd3, 7'b0000111, bits);
        frame0(3'd0, 7'b0000000, bits);
        frame0(3'd7, 7'b1111111, bits);

        // Back-to-back frames with in_valid held high.
        run = 0;
        v0 = 1'b1;
        c0 = bc[0];
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 7; i++) begin
                chk("b2b_sdata", sd0, bw[f][i]);
                chk("b2b_slast", sl0, (i == 6));
                chk("b2b_rdy", r0, (i == 6));
                chk("b2b_wvalid", wv0, (i == 0));
                chk("b2b_word", w0, bw[f]);
                if (sf0) run++;
                if (i == 2) c0 = 3'd7;
                if (i == 6) begin
                    if (f < 2) c0 = bc[f + 1];
                    else v0 = 1'b0;
                end
                @(negedge clk);
            end
        end
        chk("b2b_run", run, 21);
        chk("b2b_end_sframe", sf0, 1'b0);

        // GAP=2 instance: accepts every 10 cycles, ready only in IDLE.
        v2 = 1'b1;
        c2 = 3'd5;
        last_acc = -1;
        for (int n = 0; n < 30; n++) begin
            chk("gap_rdy", r2, ((n % 10) == 0));
            chk("gap_sframe", sf2, ((n % 10) >= 1 && (n % 10) <= 7));
            if (v2 && r2) begin
                if (last_acc >= 0) chk("gap_spacing", n - last_acc, 10);
                last_acc = n;
            end
            @(negedge clk);
        end
        v2 = 1'b0;

        // Reset in the middle of a count=6 frame.
        v0 = 1'b1;
        c0 = 3'd6;
        @(negedge clk);
        v0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_sframe", sf0, 1'b1);
        chk("mid_sdata", sd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sframe", sf0, 1'b0);
        chk("arst_sdata", sd0, 1'b0);
        chk("arst_word", w0, 7'd0);
        chk("arst_wvalid", wv0, 1'b0);
        chk("arst_rdy", r0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_sframe", sf0, 1'b0);
        chk("post_rst_rdy", r0, 1'b1);
        frame0(3'd4, 7'b0001111, bits);

        // Loopback through a seven-input ones count.
        for (int c = 0; c < 8; c++) begin
            frame0(3'(c), therm[c], bits);
            ones = 0;
            for (int j = 0; j < 7; j++) ones += int'(bits[j]);
            chk("loopback", ones, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
